mem_req_sequencer: RTL and testbench
====================================

// Module: mem_req_sequencer
// PURPOSE
//  - Upstream driver for the 32x8 memory port: read, write, addr, data_in out; data_out in.
//  - Accepts read/write commands from the test/host side over a valid/ready handshake.
//  - Buffers commands in a small in-order FIFO and issues them one at a time as memory strobes.
//  - Captures read data after a fixed latency and returns it over a valid/ready response channel.
// PARAMETERS
//  DEPTH   4  command FIFO entries; power of 2, >=2
//  ADDR_W  5  memory address width
//  DATA_W  8  memory data width
//  RD_LAT  1  cycles mem_read is held before mem_data_out is sampled; legal range 1..3
// PORTS
//  clk           in   1       single clock; all state updates on the rising edge
//  reset         in   1       asynchronous, active-high reset
//  req_valid     in   1       command valid
//  req_ready     out  1       command accepted when req_valid && req_ready
//  req_wr        in   1       1 = write, 0 = read
//  req_addr      in   ADDR_W  command address
//  req_wdata     in   DATA_W  write data (ignored for reads)
//  rsp_valid     out  1       read response valid
//  rsp_ready     in   1       response consumed when rsp_valid && rsp_ready
//  rsp_addr      out  ADDR_W  address of the returned read
//  rsp_rdata     out  DATA_W  returned read data
//  mem_read      out  1       to memory read
//  mem_write     out  1       to memory write
//  mem_addr      out  ADDR_W  to memory addr
//  mem_data_in   out  DATA_W  to memory data_in
//  mem_data_out  in   DATA_W  from memory data_out
//  busy          out  1       FSM not IDLE, or FIFO not empty
// BEHAVIOUR
//  - Reset (async): FIFO emptied, FSM forced to IDLE.
//    - All outputs 0 except req_ready = 1 (empty FIFO).
//    - Any in-flight command or pending response is dropped; strobes fall immediately, not at the next edge.
//  - FIFO
//    - req_ready = !full, decoded from a registered count of log2(DEPTH)+1 bits.
//    - A push offered while full is not accepted.
//    - Pointers wrap modulo DEPTH.
//    - Push and pop in the same cycle leave the count unchanged.
//  - FSM states: IDLE, WRITE, READ_WAIT, RESP.
//    - IDLE, FIFO non-empty: pop head at edge E1 and load mem_addr / mem_data_in.
//      - Write: mem_write=1, go to WRITE.
//      - Read: mem_read=1, go to READ_WAIT.
//    - WRITE: at edge E2, mem_write=0, go to IDLE. Write strobe is exactly 1 cycle.
//    - READ_WAIT: hold mem_read for RD_LAT cycles.
//      - At edge E1+RD_LAT: rsp_rdata <= mem_data_out, rsp_addr <= mem_addr, rsp_valid=1, mem_read=0, go to RESP.
//    - RESP: hold rsp_* stable until rsp_valid && rsp_ready.
//      - At that edge rsp_valid=0, go to IDLE.
//      - No new command issues while a response is pending.
//  - Latency
//    - Command accepted at E0 appears on the memory strobes at E1 when the FSM is IDLE.
//    - Back-to-back writes give one mem_write pulse every 2 cycles; IDLE is always visited between commands.
//  - Invariants
//    - mem_read && mem_write is never 1.
//    - mem_addr / mem_data_in hold their last values in IDLE.
//    - Commands execute strictly in FIFO order.
// CONFIGURATION
//  - MEM_REQ_STATS_EN defined: adds outputs wr_count[15:0] and rd_count[15:0].
//    - Each counts issued strobes: +1 at the edge mem_write or mem_read rises.
//    - Both reset to 0; saturate at 16'hFFFF.
//  - Undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Reset, then write addr 5 data 8'hA3 -> single 1-cycle mem_write with mem_addr=5, mem_data_in=A3; busy returns to 0.
//  2. Read addr 5, memory model returns 8'hA3 after RD_LAT=1 -> rsp_valid=1, rsp_addr=5, rsp_rdata=A3, held until rsp_ready.
//  3. Hold rsp_ready=0 and push 5 commands with DEPTH=4.
//     -> req_ready drops after 4 accepts; 5th stalls; all issue in order once rsp_ready=1.
//  4. Write 0..31 with data=addr, then read all 32 -> rdata==addr for every entry; pointer wrap is exercised.
//  5. Assert reset during READ_WAIT -> mem_read=0, rsp_valid=0, req_ready=1 asynchronously; no response ever emerges.
//  6. With MEM_REQ_STATS_EN: 3 writes + 2 reads -> wr_count=3, rd_count=2; 0 after reset.

Source files
------------

// File: rtl/mem_req_sequencer_if.sv
// ---------------------------------------------------------------------------
// mem_req_sequencer_if
//   Bundles the three channels around mem_req_sequencer:
//     req_*  host -> sequencer command channel (valid/ready)
//     rsp_*  sequencer -> host read-response channel (valid/ready)
//     mem_*  sequencer <-> 32x8 memory port strobes and data
//   Modports:
//     slave  : the sequencer's view (consumes commands, drives memory)
//     master : the environment's view (host plus memory model)
// ---------------------------------------------------------------------------
interface mem_req_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_addr, rsp_rdata,
           mem_read, mem_write, mem_addr, mem_data_in
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_addr, rsp_rdata,
           mem_read, mem_write, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_req_sequencer.sv
// ---------------------------------------------------------------------------
// mem_req_sequencer
//   Upstream driver for a 32x8 memory port. Host commands (read/write) are
//   accepted over a valid/ready channel into an in-order FIFO, issued one at
//   a time as memory strobes, and read data is captured RD_LAT cycles after
//   mem_read rises and returned over a valid/ready response channel.
//
// Ports
//   clk    in   single clock, rising edge
//   reset  in   asynchronous, active-high; empties the FIFO, forces IDLE and
//               clears every output except req_ready (which reads 1)
//   bus    slave modport of mem_req_sequencer_if (req_*, rsp_*, mem_*)
//   busy   out  FSM not IDLE or FIFO not empty
//   wr_count / rd_count (16 bit, out) only when MEM_REQ_STATS_EN is defined:
//               saturating counts of issued write / read strobes
//
// Build option
//   MEM_REQ_STATS_EN : adds wr_count / rd_count. Undefined by default.
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   ADDR_W memory address width
//   DATA_W memory data width
//   RD_LAT cycles mem_read is held before mem_data_out is sampled (1..3)
// ---------------------------------------------------------------------------
module mem_req_sequencer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_req_sequencer_if.slave     bus,
  output logic                   busy
`ifdef MEM_REQ_STATS_EN
  ,
  output logic [15:0]            wr_count,
  output logic [15:0]            rd_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ENT_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic              head_wr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  logic [ADDR_W-1:0] mem_addr_p1;
  logic [DATA_W-1:0] mem_wdata_p1;
  logic [1:0]        lat_p1;
  logic              capture;

  logic [ADDR_W-1:0] rsp_addr_p2;
  logic [DATA_W-1:0] rsp_rdata_p2;

  // Saturating 16-bit increment for the statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- FIFO (input stage) --------------------------------------------------
  assign fifo_full     = (cnt_q == CNT_W'(DEPTH));
  assign fifo_empty    = (cnt_q == '0);
  assign bus.req_ready = !fifo_full;
  assign push          = bus.req_valid && !fifo_full;
  // Only IDLE pops; a pending response therefore blocks further issue.
  assign pop           = (state_q == IDLE) && !fifo_empty;

  assign {head_wr, head_addr, head_wdata} = fifo_mem[rd_ptr_q];

  // Storage carries no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.req_wr, bus.req_addr, bus.req_wdata};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---- FSM -----------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign capture = (state_q == READ_WAIT) && (lat_p1 == 2'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = head_wr ? WRITE : READ_WAIT;
      end
      WRITE:     state_d = IDLE;
      READ_WAIT: if (capture) state_d = RESP;
      RESP:      if (bus.rsp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Strobes and response valid decode straight from the state register, so
  // an asynchronous reset drops them without waiting for a clock edge.
  always_comb begin
    bus.mem_write   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.rsp_valid   = 1'b0;
    case (state_q)
      WRITE:     bus.mem_write = 1'b1;
      READ_WAIT: bus.mem_read  = 1'b1;
      RESP:      bus.rsp_valid = 1'b1;
      default: ;
    endcase
    bus.mem_addr    = mem_addr_p1;
    bus.mem_data_in = mem_wdata_p1;
    bus.rsp_addr    = rsp_addr_p2;
    bus.rsp_rdata   = rsp_rdata_p2;
    busy            = (state_q != IDLE) || !fifo_empty;
  end

  // ---- issue stage (p1): memory address/data and read-latency counter ------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_p1  <= '0;
      mem_wdata_p1 <= '0;
      lat_p1       <= '0;
    end else begin
      if (pop) begin
        mem_addr_p1  <= head_addr;
        mem_wdata_p1 <= head_wdata;
        lat_p1       <= 2'(RD_LAT - 1);
      end else if (state_q == READ_WAIT && lat_p1 != 2'd0) begin
        lat_p1 <= lat_p1 - 2'd1;
      end
    end
  end

  // ---- response stage (p2): captured read data held until consumed ---------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_addr_p2  <= '0;
      rsp_rdata_p2 <= '0;
    end else if (capture) begin
      rsp_addr_p2  <= mem_addr_p1;
      rsp_rdata_p2 <= bus.mem_data_out;
    end
  end

`ifdef MEM_REQ_STATS_EN
  // A strobe rises exactly at the edge that pops a command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (pop) begin
      if (head_wr) wr_count <= sat_inc(wr_count);
      else         rd_count <= sat_inc(rd_count);
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_sequencer.sv
`timescale 1ns/1ps
module tb_mem_req_sequencer;

  logic clk;
  logic reset;
  logic busy;
`ifdef MEM_REQ_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;
`endif

  int checks = 0;
  int errors = 0;

  mem_req_sequencer_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  mem_req_sequencer #(
    .DEPTH(4), .ADDR_W(5), .DATA_W(8), .RD_LAT(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
`ifdef MEM_REQ_STATS_EN
    ,
    .wr_count (wr_count),
    .rd_count (rd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32x8 memory model: combinational read, write on the rising edge.
  logic [7:0] mem_model [32];
  assign bus.mem_data_out = mem_model[bus.mem_addr];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_model[i] <= 8'h00;
    end else if (bus.mem_write) begin
      mem_model[bus.mem_addr] <= bus.mem_data_in;
    end
  end

  // Issue log (rising strobes) and response log (handshakes).
  typedef struct { logic wr; logic [4:0] addr; logic [7:0] data; time t; } iss_t;
  typedef struct { logic [4:0] addr; logic [7:0] data; } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];
  logic prev_w = 1'b0;
  logic prev_r = 1'b0;
  int   overlap = 0;

  always @(negedge clk) begin
    if (bus.mem_write && !prev_w) iss_q.push_back('{1'b1, bus.mem_addr, bus.mem_data_in, $time});
    if (bus.mem_read && !prev_r)  iss_q.push_back('{1'b0, bus.mem_addr, 8'h00, $time});
    if (bus.mem_read && bus.mem_write) overlap <= overlap + 1;
    prev_w <= bus.mem_write;
    prev_r <= bus.mem_read;
  end

  always @(posedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) rsp_q.push_back('{bus.rsp_addr, bus.rsp_rdata});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic wr, input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: req_ready stayed 0 for addr %0h", a);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int base_r, input int nrsp, input int limit);
    int n = 0;
    while ((busy || (rsp_q.size() - base_r) < nrsp) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || (rsp_q.size() - base_r) != nrsp) begin
      errors++;
      $display("FAIL %s: busy=%0b responses=%0d required idle with %0d", name, busy,
               rsp_q.size() - base_r, nrsp);
    end
  endtask

  typedef struct { logic wr; logic [4:0] addr; logic [7:0] wdata; logic [7:0] exp_rdata; } vec_t;
  vec_t vecs [8];

  initial begin
    int bi, br, n;
    iss_t exp_iss [6];
    rsp_t exp_rsp [3];

    vecs[0] = '{1'b1, 5'd5,  8'hA3, 8'h00};
    vecs[1] = '{1'b0, 5'd5,  8'h00, 8'hA3};
    vecs[2] = '{1'b1, 5'd31, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 5'd0,  8'h00, 8'h00};
    vecs[4] = '{1'b0, 5'd31, 8'h00, 8'hFF};
    vecs[5] = '{1'b0, 5'd0,  8'h00, 8'h00};
    vecs[6] = '{1'b1, 5'd5,  8'h3C, 8'h00};
    vecs[7] = '{1'b0, 5'd5,  8'h00, 8'h3C};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_data_in", bus.mem_data_in, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_addr", bus.rsp_addr, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_busy", busy, 0);
`ifdef MEM_REQ_STATS_EN
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_count", rd_count, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single commands with cycle-exact expectations
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk("e1_mem_write", bus.mem_write, vecs[i].wr);
      chk("e1_mem_read", bus.mem_read, !vecs[i].wr);
      chk("e1_mem_addr", bus.mem_addr, vecs[i].addr);
      if (vecs[i].wr) chk("e1_mem_data_in", bus.mem_data_in, vecs[i].wdata);
      @(negedge clk);
      if (vecs[i].wr) begin
        chk("e2_mem_write_low", bus.mem_write, 0);
        chk("e2_busy", busy, 0);
        chk("idle_addr_hold", bus.mem_addr, vecs[i].addr);
      end else begin
        chk("e2_mem_read_low", bus.mem_read, 0);
        chk("e2_rsp_valid", bus.rsp_valid, 1);
        chk("e2_rsp_addr", bus.rsp_addr, vecs[i].addr);
        chk("e2_rsp_rdata", bus.rsp_rdata, vecs[i].exp_rdata);
        @(negedge clk);
        chk("rsp_hold_valid", bus.rsp_valid, 1);
        chk("rsp_hold_rdata", bus.rsp_rdata, vecs[i].exp_rdata);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_consumed", bus.rsp_valid, 0);
        chk("rsp_busy", busy, 0);
        bus.rsp_ready = 1'b0;
      end
    end

    // Backpressure: response pending, FIFO fills after 4 accepts
    bi = iss_q.size();
    br = rsp_q.size();
    push(1'b0, 5'd5, 8'h00);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_pending", bus.rsp_valid, 1);
    push(1'b1, 5'd7, 8'h77);
    push(1'b0, 5'd7, 8'h00);
    push(1'b1, 5'd8, 8'h88);
    chk("bp_ready_3", bus.req_ready, 1);
    push(1'b1, 5'd7, 8'h70);
    chk("bp_ready_full", bus.req_ready, 0);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 5'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall_ready", bus.req_ready, 0);
      chk("bp_stall_rsp", bus.rsp_valid, 1);
    end
    bus.rsp_ready = 1'b1;
    push(1'b0, 5'd7, 8'h00);
    wait_drain("bp_drain", br, 3, 300);
    bus.rsp_ready = 1'b0;
    exp_iss[0] = '{1'b0, 5'd5, 8'h00, 0};
    exp_iss[1] = '{1'b1, 5'd7, 8'h77, 0};
    exp_iss[2] = '{1'b0, 5'd7, 8'h00, 0};
    exp_iss[3] = '{1'b1, 5'd8, 8'h88, 0};
    exp_iss[4] = '{1'b1, 5'd7, 8'h70, 0};
    exp_iss[5] = '{1'b0, 5'd7, 8'h00, 0};
    exp_rsp[0] = '{5'd5, 8'h3C};
    exp_rsp[1] = '{5'd7, 8'h77};
    exp_rsp[2] = '{5'd7, 8'h70};
    chk("bp_issue_count", iss_q.size() - bi, 6);
    if (iss_q.size() - bi == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("bp_issue_wr", iss_q[bi+k].wr, exp_iss[k].wr);
        chk("bp_issue_addr", iss_q[bi+k].addr, exp_iss[k].addr);
        if (exp_iss[k].wr) chk("bp_issue_data", iss_q[bi+k].data, exp_iss[k].data);
      end
      for (int k = 0; k < 3; k++) begin
        chk("bp_rsp_addr", rsp_q[br+k].addr, exp_rsp[k].addr);
        chk("bp_rsp_rdata", rsp_q[br+k].data, exp_rsp[k].data);
      end
    end

    // Full sweep: write addr as data everywhere, read it all back
    bi = iss_q.size();
    br = rsp_q.size();
    bus.rsp_ready = 1'b1;
    for (int a = 0; a < 32; a++) push(1'b1, 5'(a), 8'(a));
    for (int a = 0; a < 32; a++) push(1'b0, 5'(a), 8'h00);
    wait_drain("sweep_drain", br, 32, 2000);
    bus.rsp_ready = 1'b0;
    if (rsp_q.size() - br == 32 && iss_q.size() - bi == 64) begin
      for (int a = 0; a < 32; a++) begin
        chk("sweep_rsp_addr", rsp_q[br+a].addr, a);
        chk("sweep_rsp_rdata", rsp_q[br+a].data, a);
      end
      for (int a = 1; a < 32; a++) begin
        chk("sweep_wr_spacing", 32'(iss_q[bi+a].t - iss_q[bi+a-1].t), 20);
      end
    end else begin
      chk("sweep_issue_count", iss_q.size() - bi, 64);
    end

    // Asynchronous reset while a read is waiting on memory
    bi = iss_q.size();
    br = rsp_q.size();
    push(1'b0, 5'd9, 8'h00);
    push(1'b1, 5'd10, 8'h55);
    chk("ar_mem_read_before", bus.mem_read, 1);
    reset = 1'b1;
    #1;
    chk("ar_mem_read", bus.mem_read, 0);
    chk("ar_mem_write", bus.mem_write, 0);
    chk("ar_rsp_valid", bus.rsp_valid, 0);
    chk("ar_req_ready", bus.req_ready, 1);
    chk("ar_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("ar_no_response", rsp_q.size() - br, 0);
    chk("ar_no_more_issue", iss_q.size() - bi, 1);
    chk("ar_rsp_valid_after", bus.rsp_valid, 0);
    chk("ar_busy_after", busy, 0);

`ifdef MEM_REQ_STATS_EN
    chk("st_wr_zero", wr_count, 0);
    chk("st_rd_zero", rd_count, 0);
    br = rsp_q.size();
    push(1'b1, 5'd1, 8'h11);
    push(1'b1, 5'd2, 8'h22);
    push(1'b1, 5'd3, 8'h33);
    push(1'b0, 5'd1, 8'h00);
    push(1'b0, 5'd2, 8'h00);
    wait_drain("st_drain", br, 2, 300);
    chk("st_wr_count", wr_count, 3);
    chk("st_rd_count", rd_count, 2);
    reset = 1'b1;
    #1;
    chk("st_wr_reset", wr_count, 0);
    chk("st_rd_reset", rd_count, 0);
    @(negedge clk);
    reset = 1'b0;
`endif
    bus.rsp_ready = 1'b0;
    @(negedge clk);

    chk("no_rd_wr_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
